// File: rtl/atm_acct_txn_seq.sv
// Account transaction sequencer: drives the account register file through a
// read-check-write sequence per request and returns status plus balance.
//
// state | meaning
// IDLE  | ready for a request; latches op/acct/amt on accept
// READ  | register file output valid; evaluate new balance and status
// WRITE | commit new balance if required; bump transaction counter
// RESP  | hold response until the consumer takes it
module atm_acct_txn_seq #(
    parameter int ACCT_W = 4,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ACCT_W-1:0] req_acct,
    input  logic [DATA_W-1:0] req_amt,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_status,
    output logic [DATA_W-1:0] rsp_balance,
    output logic [ACCT_W-1:0] rf_sel,
    output logic              rf_we,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic [CNT_W-1:0]  txn_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [1:0] OP_BAL = 2'b00;
    localparam logic [1:0] OP_DEP = 2'b01;
    localparam logic [1:0] OP_WDR = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_INS = 2'b01;
    localparam logic [1:0] ST_OVF = 2'b10;

    logic [1:0]        state;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] amt_q;
    logic              wr_q;
    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] new_bal;
    logic [1:0]        new_st;
    logic              new_wr;

    assign req_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    // Gated by rst so a reset landing on WRITE never lets a write through.
    assign rf_we     = rst && (state == S_WRITE) && wr_q;

    // Evaluate the latched operation against the balance read back this cycle.
    always_comb begin
        sum     = {1'b0, rf_rdata} + {1'b0, amt_q};
        new_bal = rf_rdata;
        new_st  = ST_OK;
        new_wr  = 1'b0;
        case (op_q)
            OP_DEP: begin
                if (sum[DATA_W]) begin
                    new_st = ST_OVF;
                end else begin
                    new_bal = sum[DATA_W-1:0];
                    new_wr  = 1'b1;
                end
            end
            OP_WDR: begin
                if (amt_q > rf_rdata) begin
                    new_st = ST_INS;
                end else begin
                    new_bal = rf_rdata - amt_q;
                    new_wr  = 1'b1;
                end
            end
            OP_CLR: begin
                new_bal = '0;
                new_wr  = 1'b1;
            end
            OP_BAL:  ;
            default: ;
        endcase
    end

    // Sequencer state, request latches, response registers and commit counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            op_q        <= OP_BAL;
            amt_q       <= '0;
            wr_q        <= 1'b0;
            rf_sel      <= '0;
            rf_wdata    <= '0;
            rsp_status  <= ST_OK;
            rsp_balance <= '0;
            txn_cnt     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q   <= req_op;
                        amt_q  <= req_amt;
                        rf_sel <= req_acct;
                        state  <= S_READ;
                    end
                end
                S_READ: begin
                    rf_wdata    <= new_bal;
                    rsp_balance <= new_bal;
                    rsp_status  <= new_st;
                    wr_q        <= new_wr;
                    state       <= S_WRITE;
                end
                S_WRITE: begin
                    if (wr_q && (txn_cnt != '1)) begin
                        txn_cnt <= txn_cnt + CNT_W'(1);
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_acct_txn_seq.sv
// Bench for atm_acct_txn_seq: a 16-entry register file, a transaction-level
// reference model, a per-cycle compare process, directed scenarios and a
// randomized run.
module tb_atm_acct_txn_seq;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_acct = '0;
    logic [DW-1:0] req_amt = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [DW-1:0] rsp_balance;
    logic [AW-1:0] rf_sel;
    logic          rf_we;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rdata;
    logic [CW-1:0] txn_cnt;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int we_cnt = 0;

    atm_acct_txn_seq #(.ACCT_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_acct   (req_acct),
        .req_amt    (req_amt),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_status (rsp_status),
        .rsp_balance(rsp_balance),
        .rf_sel     (rf_sel),
        .rf_we      (rf_we),
        .rf_wdata   (rf_wdata),
        .rf_rdata   (rf_rdata),
        .txn_cnt    (txn_cnt)
    );

    always #5 clk = ~clk;

    // Account register file: combinational read, write on the clock edge.
    logic [DW-1:0] rf_mem [16] = '{default: '0};
    assign rf_rdata = rf_mem[rf_sel];
    always @(posedge clk) if (rf_we) rf_mem[rf_sel] <= rf_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: transaction timeline (0 idle, 1 read, 2 write, 3 response)
    longint        e_mem [16] = '{default: 0};
    int            phase = 0;
    int            m_cnt = 0;
    logic [AW-1:0] m_acct = '0;
    logic [AW-1:0] m_sel = '0;
    longint        m_new = 0;
    logic [1:0]    m_st = 2'b00;
    bit            m_wr = 1'b0;
    longint        m_wdata = 0;
    longint        m_bal = 0;
    logic [1:0]    m_status = 2'b00;

    always @(posedge clk) begin
        longint old_v;
        longint amt_v;
        if (!rst) begin
            phase = 0; m_cnt = 0; m_sel = '0; m_wdata = 0; m_bal = 0; m_status = 2'b00;
        end else begin
            case (phase)
                0: if (req_valid) begin
                    m_acct = req_acct;
                    m_sel  = req_acct;
                    old_v  = e_mem[req_acct];
                    amt_v  = longint'(req_amt);
                    m_new  = old_v; m_st = 2'b00; m_wr = 1'b0;
                    case (req_op)
                        2'b01: if (old_v + amt_v > 64'hFFFF_FFFF) m_st = 2'b10;
                               else begin m_new = old_v + amt_v; m_wr = 1'b1; end
                        2'b10: if (amt_v > old_v) m_st = 2'b01;
                               else begin m_new = old_v - amt_v; m_wr = 1'b1; end
                        2'b11: begin m_new = 0; m_wr = 1'b1; end
                        default: ;
                    endcase
                    phase = 1;
                end
                1: begin m_wdata = m_new; m_bal = m_new; m_status = m_st; phase = 2; end
                2: begin
                    if (m_wr) begin
                        e_mem[m_acct] = m_new;
                        if (m_cnt < 65535) m_cnt++;
                    end
                    phase = 3;
                end
                default: if (rsp_ready) phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (rf_we) we_cnt++;
        if (chk_en) begin
            chk("req_ready",   64'(req_ready),   64'(phase == 0));
            chk("rsp_valid",   64'(rsp_valid),   64'(phase == 3));
            chk("rf_we",       64'(rf_we),       64'(phase == 2 && m_wr && rst));
            chk("rf_sel",      64'(rf_sel),      64'(m_sel));
            chk("rf_wdata",    64'(rf_wdata),    64'(m_wdata));
            chk("rsp_status",  64'(rsp_status),  64'(m_status));
            chk("rsp_balance", 64'(rsp_balance), 64'(m_bal));
            chk("txn_cnt",     64'(txn_cnt),     64'(m_cnt));
        end
    end

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk(name, 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        if (!ok) chk(name, 64'd0, 64'd1);
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] amt,
                          output logic [1:0] st, output logic [DW-1:0] bal);
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_acct = a; req_amt = amt; rsp_ready = 1'b0;
        wait_ready("accept_timeout");
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_rsp("rsp_timeout");
        st  = rsp_status;
        bal = rsp_balance;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    logic [1:0]    st;
    logic [DW-1:0] bal;
    int            w0;
    int            acc_n;
    int            acc_first;
    int            acc_last;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_txn_cnt",   64'(txn_cnt),   64'd0);
        chk("rst_rf_sel",    64'(rf_sel),    64'd0);

        // Deposit into empty account 3
        w0 = we_cnt;
        do_txn(2'b01, 4'd3, 32'd100, st, bal);
        chk("t1_status", 64'(st), 64'd0);
        chk("t1_bal",    64'(bal), 64'd100);
        chk("t1_we_pulses", 64'(we_cnt - w0), 64'd1);
        chk("t1_cnt",    64'(txn_cnt), 64'd1);
        chk("t1_rf3",    64'(rf_mem[3]), 64'd100);

        // Insufficient funds, then exact withdraw
        w0 = we_cnt;
        do_txn(2'b10, 4'd3, 32'd150, st, bal);
        chk("t2a_status", 64'(st), 64'd1);
        chk("t2a_bal",    64'(bal), 64'd100);
        chk("t2a_no_we",  64'(we_cnt - w0), 64'd0);
        do_txn(2'b10, 4'd3, 32'd100, st, bal);
        chk("t2b_status", 64'(st), 64'd0);
        chk("t2b_bal",    64'(bal), 64'd0);
        chk("t2b_cnt",    64'(txn_cnt), 64'd2);

        // Overflow boundary on account 5
        do_txn(2'b01, 4'd5, 32'hFFFF_FFF0, st, bal);
        w0 = we_cnt;
        do_txn(2'b01, 4'd5, 32'h20, st, bal);
        chk("t3a_status", 64'(st), 64'd2);
        chk("t3a_bal",    64'(bal), 64'hFFFF_FFF0);
        chk("t3a_no_we",  64'(we_cnt - w0), 64'd0);
        do_txn(2'b01, 4'd5, 32'h0F, st, bal);
        chk("t3b_status", 64'(st), 64'd0);
        chk("t3b_bal",    64'(bal), 64'hFFFF_FFFF);
        chk("t3b_cnt",    64'(txn_cnt), 64'd4);

        // Response back-pressure with a request waiting
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b01; req_acct = 4'd1; req_amt = 32'd5; rsp_ready = 1'b0;
        wait_ready("t4_accept_timeout");
        @(posedge clk); #1;
        req_op = 2'b00;
        wait_rsp("t4_rsp_timeout");
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("t4_hold_ready", 64'(req_ready),   64'd0);
            chk("t4_hold_valid", 64'(rsp_valid),   64'd1);
            chk("t4_hold_bal",   64'(rsp_balance), 64'd5);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        @(negedge clk);
        chk("t4_idle_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        chk("t4_accepted", 64'(req_ready), 64'd0);
        wait_rsp("t4_rsp2_timeout");
        chk("t4_bal2", 64'(rsp_balance), 64'd5);
        chk("t4_st2",  64'(rsp_status),  64'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;

        // Reset while the write of a deposit to account 7 is pending
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b01; req_acct = 4'd7; req_amt = 32'd9;
        wait_ready("t5_accept_timeout");
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_we_suppressed", 64'(rf_we), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("t5_cnt",       64'(txn_cnt),   64'd0);
        chk("t5_rf7",       64'(rf_mem[7]), 64'd0);

        // Clear then back-to-back balance reads with rsp_ready held
        do_txn(2'b01, 4'd2, 32'd50, st, bal);
        do_txn(2'b11, 4'd2, 32'd77, st, bal);
        chk("t6_clear_bal", 64'(bal), 64'd0);
        w0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 2'b00; req_acct = 4'd2; rsp_ready = 1'b1;
        acc_n = 0; acc_first = 0; acc_last = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (req_ready) begin
                if (acc_n == 0) acc_first = i;
                acc_last = i;
                acc_n++;
            end
            if (rsp_valid) begin
                chk("t6_bal", 64'(rsp_balance), 64'd0);
                chk("t6_st",  64'(rsp_status),  64'd0);
            end
        end
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("t6_accepts", 64'(acc_n), 64'd4);
        chk("t6_spacing", 64'(acc_last - acc_first), 64'd12);
        chk("t6_no_we",   64'(we_cnt - w0), 64'd0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            logic [AW-1:0] a;
            @(posedge clk); #1;
            a = AW'($urandom_range(0, 5));
            req_valid = ($urandom % 3) != 0;
            req_op    = 2'($urandom);
            req_acct  = a;
            case ($urandom % 4)
                0: req_amt = DW'($urandom % 200);
                1: req_amt = DW'($urandom);
                2: req_amt = DW'(e_mem[a]);
                default: req_amt = DW'(64'hFFFF_FFFF - e_mem[a] + longint'($urandom_range(0, 2)) - 1);
            endcase
            rsp_ready = $urandom % 2;
            rst       = ($urandom % 300) != 0;
        end
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 16; i++) chk("final_rf", 64'(rf_mem[i]), 64'(e_mem[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
